// File: rtl/axis_snoop_rr_arbiter_if.sv
// AXI-Stream bundle for the snoop arbiter: four snoop inputs and one merged output.
// master = arbiter side, slave = surrounding FIFOs and sink.
interface axis_snoop_rr_arbiter_if #(
    parameter int PORT_WIDTH = 8
);
    logic [3:0]              s_axis_tvalid;
    logic [4*PORT_WIDTH-1:0] s_axis_tdata;
    logic [3:0]              s_axis_tlast;
    logic [3:0]              s_axis_tready;
    logic                    m_axis_tready;
    logic [PORT_WIDTH-1:0]   m_axis_tdata;
    logic                    m_axis_tlast;
    logic                    m_axis_tvalid;

    modport master (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tlast, m_axis_tvalid
    );

    modport slave (
        output s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tlast, m_axis_tvalid
    );
endinterface

// File: rtl/axis_snoop_rr_arbiter.sv
// Round-robin merge of up to four snoop streams into one debug stream.
// Grant is held for a whole packet; an optional header beat tags channel and sequence.
module axis_snoop_rr_arbiter #(
    parameter int NUM_INTERFACES = 4,
    parameter int PORT_WIDTH     = 8,
    parameter int HEADER_EN      = 1
) (
    input  logic                          axis_aclk,
    input  logic                          axis_aresetn,
    axis_snoop_rr_arbiter_if.master       axis,
    output logic                          busy,
    output logic [1:0]                    cur_channel
);
    typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;

    state_t                       state, state_nxt;
    logic [1:0]                   grant, last_grant, pick;
    logic                         found, eop;
    logic [3:0]                   act_mask, req;
    logic [3:0][5:0]              seq;
    logic [3:0][PORT_WIDTH-1:0]   s_data;
    logic [PORT_WIDTH-1:0]        hdr;

    for (genvar i = 0; i < 4; i++) begin : g_act
        assign act_mask[i] = (i < NUM_INTERFACES);
    end

    assign req    = axis.s_axis_tvalid & act_mask;
    assign s_data = axis.s_axis_tdata;

    // Search starts just after the previous winner, wrapping over the active channels only.
    always_comb begin
        int idx;
        idx   = 0;
        pick  = last_grant;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (k <= NUM_INTERFACES) begin
                idx = (int'(last_grant) + k) % NUM_INTERFACES;
                if (!found && req[2'(idx)]) begin
                    found = 1'b1;
                    pick  = 2'(idx);
                end
            end
        end
    end

    always_comb begin
        hdr      = '0;
        hdr[7:0] = {seq[grant], grant};
    end

    assign eop = (state == DATA) && axis.s_axis_tvalid[grant] &&
                 axis.m_axis_tready && axis.s_axis_tlast[grant];

    always_comb begin
        state_nxt          = state;
        axis.m_axis_tvalid = 1'b0;
        axis.m_axis_tlast  = 1'b0;
        axis.m_axis_tdata  = '0;
        axis.s_axis_tready = '0;
        case (state)
            IDLE: begin
                if (found) state_nxt = (HEADER_EN != 0) ? HEADER : DATA;
            end
            HEADER: begin
                axis.m_axis_tvalid = 1'b1;
                axis.m_axis_tdata  = hdr;
                if (axis.m_axis_tready) state_nxt = DATA;
            end
            DATA: begin
                axis.m_axis_tvalid        = axis.s_axis_tvalid[grant];
                axis.m_axis_tdata         = s_data[grant];
                axis.m_axis_tlast         = axis.s_axis_tlast[grant];
                axis.s_axis_tready[grant] = axis.m_axis_tready;
                if (eop) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state      <= IDLE;
            grant      <= 2'd0;
            last_grant <= 2'(NUM_INTERFACES - 1);
            seq        <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && found) grant <= pick;
            if (eop) begin
                seq[grant] <= seq[grant] + 6'd1;
                last_grant <= grant;
            end
        end
    end

    assign busy        = (state != IDLE);
    assign cur_channel = grant;
endmodule

// File: tb/tb_axis_snoop_rr_arbiter.sv
// Directed bench: header-enabled 4-channel arbiter plus a header-less 3-channel instance.
module tb_axis_snoop_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       busy1, busy0;
    logic [1:0] cur1, cur0;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    axis_snoop_rr_arbiter_if #(.PORT_WIDTH(8)) b1 ();
    axis_snoop_rr_arbiter_if #(.PORT_WIDTH(8)) b0 ();

    axis_snoop_rr_arbiter #(.NUM_INTERFACES(4), .PORT_WIDTH(8), .HEADER_EN(1)) u_hdr (
        .axis_aclk(clk), .axis_aresetn(rst_n), .axis(b1), .busy(busy1), .cur_channel(cur1));

    axis_snoop_rr_arbiter #(.NUM_INTERFACES(3), .PORT_WIDTH(8), .HEADER_EN(0)) u_nohdr (
        .axis_aclk(clk), .axis_aresetn(rst_n), .axis(b0), .busy(busy0), .cur_channel(cur0));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic v, input logic [7:0] d, input logic l);
        b1.s_axis_tvalid[ch]        = v;
        b1.s_axis_tdata[ch*8 +: 8]  = d;
        b1.s_axis_tlast[ch]         = l;
    endtask

    task automatic clr_all();
        for (int i = 0; i < 4; i++) set_ch(i, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] e;
        clr_all();
        b1.m_axis_tready = 1'b0;
        b0.s_axis_tvalid = '0;
        b0.s_axis_tdata  = '0;
        b0.s_axis_tlast  = '0;
        b0.m_axis_tready = 1'b0;
        #2;
        chk("rst_vld",   b1.m_axis_tvalid, 0);
        chk("rst_data",  b1.m_axis_tdata, 0);
        chk("rst_last",  b1.m_axis_tlast, 0);
        chk("rst_rdy",   b1.s_axis_tready, 0);
        chk("rst_busy",  busy1, 0);
        chk("rst_cur",   cur1, 0);
        step();
        rst_n = 1'b1;

        // 3-beat packet on channel 0
        set_ch(0, 1, 8'h11, 0); b1.m_axis_tready = 1'b1; #1;
        chk("t1_idle_vld", b1.m_axis_tvalid, 0);
        chk("t1_idle_busy", busy1, 0);
        step();
        chk("t1_hdr", b1.m_axis_tdata, 8'h00);
        chk("t1_hdr_vld", b1.m_axis_tvalid, 1);
        chk("t1_hdr_rdy", b1.s_axis_tready, 0);
        chk("t1_hdr_busy", busy1, 1);
        step();
        chk("t1_d0", b1.m_axis_tdata, 8'h11);
        chk("t1_d0_rdy", b1.s_axis_tready, 4'b0001);
        step(); set_ch(0, 1, 8'h22, 0); #1;
        chk("t1_d1", b1.m_axis_tdata, 8'h22);
        step(); set_ch(0, 1, 8'h33, 1); #1;
        chk("t1_d2", b1.m_axis_tdata, 8'h33);
        chk("t1_d2_last", b1.m_axis_tlast, 1);
        step(); set_ch(0, 0, 8'h00, 0); #1;
        chk("t1_end_busy", busy1, 0);
        chk("t1_end_vld", b1.m_axis_tvalid, 0);

        // all four channels requesting single-beat packets
        do_reset();
        for (int i = 0; i < 4; i++) set_ch(i, 1, 8'hA0 + 8'(i), 1);
        for (int k = 0; k < 6; k++) begin
            e = 8'(((k / 4) << 2) | (k % 4));
            step();
            chk("t2_hdr", b1.m_axis_tdata, e);
            chk("t2_cur", cur1, k % 4);
            step();
            chk("t2_data", b1.m_axis_tdata, 8'hA0 + 8'(k % 4));
            chk("t2_last", b1.m_axis_tlast, 1);
            step();
        end
        clr_all(); #1;

        // channel 1 holds the grant while channel 0 requests
        set_ch(1, 1, 8'h51, 0); #1;
        step();
        chk("t3_hdr1", b1.m_axis_tdata, 8'h09);
        chk("t3_cur1", cur1, 1);
        step(); set_ch(0, 1, 8'h61, 1); #1;
        chk("t3_d0", b1.m_axis_tdata, 8'h51);
        chk("t3_rdy_a", b1.s_axis_tready, 4'b0010);
        step(); set_ch(1, 1, 8'h52, 1); #1;
        chk("t3_d1", b1.m_axis_tdata, 8'h52);
        chk("t3_rdy_b", b1.s_axis_tready, 4'b0010);
        chk("t3_cur_lock", cur1, 1);
        step(); set_ch(1, 0, 8'h00, 0); #1;
        chk("t3_idle_rdy", b1.s_axis_tready, 0);
        chk("t3_idle_busy", busy1, 0);
        step();
        chk("t3_cur0", cur1, 0);
        chk("t3_hdr0", b1.m_axis_tdata, 8'h08);
        step();
        chk("t3_d_ch0", b1.m_axis_tdata, 8'h61);
        step(); set_ch(0, 0, 8'h00, 0); #1;

        // sink backpressure during header and data
        b1.m_axis_tready = 1'b0; set_ch(3, 1, 8'h71, 0); #1;
        step();
        chk("t4_hdr", b1.m_axis_tdata, 8'h07);
        step();
        chk("t4_hdr_hold", b1.m_axis_tdata, 8'h07);
        chk("t4_hdr_busy", busy1, 1);
        b1.m_axis_tready = 1'b1;
        step(); b1.m_axis_tready = 1'b0; #1;
        chk("t4_d0", b1.m_axis_tdata, 8'h71);
        chk("t4_d0_rdy", b1.s_axis_tready, 0);
        step();
        chk("t4_d0_hold", b1.m_axis_tdata, 8'h71);
        chk("t4_d0_vld", b1.m_axis_tvalid, 1);
        b1.m_axis_tready = 1'b1; #1;
        chk("t4_d0_rdy1", b1.s_axis_tready, 4'b1000);
        step(); set_ch(3, 1, 8'h72, 1); #1;
        chk("t4_d1", b1.m_axis_tdata, 8'h72);
        step(); set_ch(3, 0, 8'h00, 0); #1;
        chk("t4_end_busy", busy1, 0);

        // sequence wrap on channel 2
        do_reset();
        set_ch(2, 1, 8'hC2, 1);
        for (int n = 0; n < 65; n++) begin
            e = 8'(((n % 64) << 2) | 2);
            step();
            chk("t5_hdr", b1.m_axis_tdata, e);
            step();
            step();
        end
        set_ch(2, 0, 8'h00, 0); #1;

        // reset mid-packet on channel 3
        do_reset();
        set_ch(3, 1, 8'h80, 1);
        step();
        chk("t6_hdr_a", b1.m_axis_tdata, 8'h03);
        step();
        step(); set_ch(3, 1, 8'h81, 0);
        step();
        chk("t6_hdr_b", b1.m_axis_tdata, 8'h07);
        step();
        chk("t6_d0", b1.m_axis_tdata, 8'h81);
        step(); set_ch(3, 1, 8'h82, 0); #1;
        chk("t6_d1", b1.m_axis_tdata, 8'h82);
        rst_n = 1'b0; #1;
        chk("t6_rst_vld", b1.m_axis_tvalid, 0);
        chk("t6_rst_rdy", b1.s_axis_tready, 0);
        chk("t6_rst_busy", busy1, 0);
        step(); rst_n = 1'b1; set_ch(3, 1, 8'h91, 1);
        step();
        chk("t6_hdr_c", b1.m_axis_tdata, 8'h03);
        step();
        step(); set_ch(3, 0, 8'h00, 0);

        // header-less, 3-channel instance
        b0.m_axis_tready = 1'b1;
        b0.s_axis_tvalid = 4'b1000; b0.s_axis_tdata = 32'hEE000000; b0.s_axis_tlast = 4'b1000;
        step(); step();
        chk("t7_ign_busy", busy0, 0);
        chk("t7_ign_rdy", b0.s_axis_tready, 0);
        b0.s_axis_tvalid = 4'b0001; b0.s_axis_tdata = 32'h0000003C; b0.s_axis_tlast = 4'b0000; #1;
        chk("t7_idle_vld", b0.m_axis_tvalid, 0);
        step();
        chk("t7_d0_vld", b0.m_axis_tvalid, 1);
        chk("t7_d0", b0.m_axis_tdata, 8'h3C);
        chk("t7_d0_last", b0.m_axis_tlast, 0);
        chk("t7_d0_rdy", b0.s_axis_tready, 4'b0001);
        step(); b0.s_axis_tdata = 32'h0000003D; b0.s_axis_tlast = 4'b0001; #1;
        chk("t7_d1", b0.m_axis_tdata, 8'h3D);
        chk("t7_d1_last", b0.m_axis_tlast, 1);
        step(); b0.s_axis_tvalid = 4'b0000; b0.s_axis_tlast = 4'b0000; #1;
        chk("t7_end_busy", busy0, 0);
        chk("t7_end_vld", b0.m_axis_tvalid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
